// File: rtl/wave_gen_pkg.sv
// wave_gen_pkg: shared FSM state encoding and DAC framing constants for the SPI DAC scheduler.
package wave_gen_pkg;
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
    localparam int FRAME_BITS = 16;
    localparam logic [3:0] CMD_WRITE_UPDATE = 4'b0011;
    localparam logic [3:0] CMD_POWER_DOWN = 4'b0100;
endpackage

// File: rtl/spi_dac_shifter.sv
// spi_dac_shifter: parallel-load frame shift register with registered sclk/mosi and
// the half-period timebase, all stepped by strobes from the scheduler FSM.
module spi_dac_shifter #(
    parameter int CLK_DIV = 2,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             rise_i,
    input  logic             fall_i,
    input  logic             drive_i,
    output logic             hp_done_o,
    output logic             sclk_o,
    output logic             mosi_o
);
    localparam int HW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    logic [HW-1:0] hp_q, hp_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic sclk_q, sclk_d, mosi_q, mosi_d;
    assign hp_done_o = hp_q == HW'(CLK_DIV - 1);
    assign sclk_o = sclk_q;
    assign mosi_o = mosi_q;
    // mosi follows the next shifter MSB so it changes on the same edge as sclk falls
    always_comb begin
        hp_d = (!run_i || hp_done_o) ? '0 : hp_q + 1'b1;
        sh_d = load_i ? data_i : fall_i ? sh_q << 1 : sh_q;
        sclk_d = rise_i ? 1'b1 : fall_i ? 1'b0 : sclk_q;
        mosi_d = drive_i & sh_d[WIDTH-1];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hp_q <= '0;
            sh_q <= '0;
            sclk_q <= 1'b0;
            mosi_q <= 1'b0;
        end else begin
            hp_q <= hp_d;
            sh_q <= sh_d;
            sclk_q <= sclk_d;
            mosi_q <= mosi_d;
        end
    end
endmodule

// File: rtl/spi_dac_frame_scheduler.sv
// spi_dac_frame_scheduler: buffers one generator sample and ships it as a {cmd, sample, pad}
// SPI mode-0 frame; excess samples are dropped and flagged. OVERRUN_CNT_EN adds overrun_cnt_o.
module spi_dac_frame_scheduler
    import wave_gen_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int DATA_WIDTH = 8,
    parameter int CMD_WIDTH = 4,
    parameter int PAD_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable_i,
    input  logic [CMD_WIDTH-1:0]  cmd_i,
    input  logic [DATA_WIDTH-1:0] sample_i,
    input  logic                  sample_valid_i,
    output logic                  sample_ready_o,
    output logic                  spi_clk_o,
    output logic                  spi_mosi_o,
    output logic                  spi_cs_o,
    output logic                  busy_o,
    output logic                  overrun_o
`ifdef OVERRUN_CNT_EN
    ,
    output logic [7:0]            overrun_cnt_o
`endif
);
    localparam int FRM = CMD_WIDTH + DATA_WIDTH + PAD_WIDTH;
    localparam int BW = $clog2(FRM) + 1;
    state_t state_q, state_d;
    logic buf_full_q, buf_full_d, ovr_q, ovr_d, cs_q, cs_d;
    logic [DATA_WIDTH-1:0] buf_q, buf_d;
    logic [BW-1:0] bit_q, bit_d;
    logic start_frame, accept, hp_done, rise, fall, last, drive;

    assign start_frame = state_q == IDLE && buf_full_q && enable_i;
    assign sample_ready_o = enable_i && (!buf_full_q || start_frame);
    assign accept = sample_valid_i && sample_ready_o;
    assign busy_o = state_q != IDLE;
    assign spi_cs_o = cs_q;
    assign overrun_o = ovr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bit_q <= '0;
            cs_q <= 1'b1;
            buf_full_q <= 1'b0;
            buf_q <= '0;
            ovr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q <= bit_d;
            cs_q <= cs_d;
            buf_full_q <= buf_full_d;
            buf_q <= buf_d;
            ovr_q <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start_frame ? SETUP : IDLE;
            SETUP:   state_d = hp_done ? SHIFT : SETUP;
            SHIFT:   state_d = last ? HOLD : SHIFT;
            HOLD:    state_d = hp_done ? GAP : HOLD;
            GAP:     state_d = hp_done ? IDLE : GAP;
            default: state_d = IDLE;
        endcase
    end

    // SHIFT ends one low half-period after the last falling edge, keeping cs low 2*FRM+2 half-periods
    always_comb begin
        rise = hp_done && (state_q == SETUP || (state_q == SHIFT && !spi_clk_o && bit_q != BW'(FRM)));
        fall = hp_done && state_q == SHIFT && spi_clk_o;
        last = hp_done && state_q == SHIFT && !spi_clk_o && bit_q == BW'(FRM);
        drive = state_d == SETUP || state_d == SHIFT;
        cs_d = !(drive || state_d == HOLD);
        bit_d = start_frame ? '0 : fall ? bit_q + 1'b1 : bit_q;
        buf_full_d = !enable_i ? 1'b0 : accept ? 1'b1 : start_frame ? 1'b0 : buf_full_q;
        buf_d = accept ? sample_i : buf_q;
        ovr_d = sample_valid_i && !sample_ready_o && enable_i;
    end

    spi_dac_shifter #(.CLK_DIV(CLK_DIV), .WIDTH(FRM)) u_shifter (
        .clk(clk),
        .rst_n(rst_n),
        .run_i(busy_o),
        .load_i(start_frame),
        .data_i({cmd_i, buf_q, {PAD_WIDTH{1'b0}}}),
        .rise_i(rise),
        .fall_i(fall),
        .drive_i(drive),
        .hp_done_o(hp_done),
        .sclk_o(spi_clk_o),
        .mosi_o(spi_mosi_o)
    );

`ifdef OVERRUN_CNT_EN
    logic en_q;
    logic [7:0] cnt_q, cnt_d;
    assign cnt_d = (enable_i && !en_q) ? 8'h00 : (ovr_d && cnt_q != 8'hFF) ? cnt_q + 1'b1 : cnt_q;
    assign overrun_cnt_o = cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q <= 1'b0;
            cnt_q <= 8'h00;
        end else begin
            en_q <= enable_i;
            cnt_q <= cnt_d;
        end
    end
`endif
endmodule

// File: tb/tb_spi_dac_frame_scheduler.sv
// tb_spi_dac_frame_scheduler: directed table-driven frame checks plus back-to-back,
// overrun, disable and async-reset sequences for spi_dac_frame_scheduler.
module tb_spi_dac_frame_scheduler;
    logic clk = 0, rst_n = 1, enable = 0, valid = 0;
    logic [3:0] cmd = 4'b0011;
    logic [7:0] sample = 8'h00;
    logic ready, sclk, mosi, cs, busy, overrun;
`ifdef OVERRUN_CNT_EN
    logic [7:0] ovr_cnt;
`endif

    spi_dac_frame_scheduler dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable_i(enable),
        .cmd_i(cmd),
        .sample_i(sample),
        .sample_valid_i(valid),
        .sample_ready_o(ready),
        .spi_clk_o(sclk),
        .spi_mosi_o(mosi),
        .spi_cs_o(cs),
        .busy_o(busy),
        .overrun_o(overrun)
`ifdef OVERRUN_CNT_EN
        ,
        .overrun_cnt_o(ovr_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Frame monitor: captures mosi on each sclk rise while cs is low
    logic [15:0] word = 0, last_word = 0;
    logic [15:0] words[$];
    int nbits = 0, last_bits = 0, fall_cyc = 0, fall_prev = 0, last_len = 0, frames = 0, ovr_pulses = 0;
    logic cs_p = 1, sclk_p = 0;
    always @(negedge clk) begin
        if (cs_p && !cs) begin
            fall_prev = fall_cyc;
            fall_cyc = cyc;
            word = 0;
            nbits = 0;
        end
        if (!cs && sclk && !sclk_p) begin
            word = {word[14:0], mosi};
            nbits++;
        end
        if (!cs_p && cs) begin
            last_len = cyc - fall_cyc;
            last_word = word;
            last_bits = nbits;
            words.push_back(word);
            frames++;
        end
        if (overrun) ovr_pulses++;
        cs_p = cs;
        sclk_p = sclk;
    end

    int n_pass = 0, n_tot = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    task automatic do_reset();
        rst_n = 0;
        enable = 0;
        valid = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] s, output int acc);
        @(negedge clk);
        sample = s;
        valid = 1;
        #1 chk("ready_on_send", ready, 1);
        @(negedge clk);
        valid = 0;
        acc = cyc;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int k = 0;
        while (frames < target && k < budget) begin
            @(negedge clk);
            #1 k++;
        end
        chk("frame_timeout", frames >= target, 1);
    endtask

    task automatic wait_bits(input int target, input int budget);
        int k = 0;
        while (nbits < target && k < budget) begin
            @(negedge clk);
            #1 k++;
        end
        chk("bit_timeout", nbits >= target, 1);
    endtask

    typedef struct {
        logic [3:0]  cmd;
        logic [7:0]  smp;
        logic [15:0] exp;
    } vec_t;
    vec_t tv[5];

    initial begin
        int acc, f, o0, w0;
        logic b1, b2, b3;
        tv[0] = '{4'b0011, 8'hA5, 16'h3A50};
        tv[1] = '{4'b0100, 8'h3C, 16'h43C0};
        tv[2] = '{4'b0011, 8'h00, 16'h3000};
        tv[3] = '{4'b1111, 8'hFF, 16'hFFF0};
        tv[4] = '{4'b1010, 8'h81, 16'hA810};

        #2 rst_n = 0;
        #1 chk("reset_outputs", {cs, sclk, mosi, busy, ready, overrun}, 6'b100000);
        do_reset();
        chk("idle_disabled", {cs, sclk, mosi, busy, ready, overrun}, 6'b100000);

        enable = 1;
        for (int i = 0; i < 5; i++) begin
            cmd = tv[i].cmd;
            f = frames;
            send(tv[i].smp, acc);
            wait_frames(f + 1, 200);
            chk("frame_word", last_word, tv[i].exp);
            chk("frame_bits", last_bits, 16);
            chk("cs_low_len", last_len, 68);
            chk("cs_latency", fall_cyc - acc, 1);
            b1 = busy;
            @(negedge clk);
            #1 b2 = busy;
            @(negedge clk);
            #1 b3 = busy;
            chk("gap_busy", {b1, b2, b3, cs}, 4'b1101);
        end

        // back-to-back frames
        do_reset();
        enable = 1;
        cmd = 4'b0011;
        f = frames;
        o0 = ovr_pulses;
        w0 = words.size();
        send(8'h01, acc);
        repeat (9) @(negedge clk);
        send(8'hFE, acc);
        wait_frames(f + 2, 300);
        chk("b2b_word0", words[w0], 16'h3010);
        chk("b2b_word1", words[w0 + 1], 16'h3FE0);
        chk("b2b_period", fall_cyc - fall_prev, 71);
        chk("b2b_no_overrun", ovr_pulses - o0, 0);

        // overrun: valid every cycle for 80 cycles
        do_reset();
        enable = 1;
        f = frames;
        o0 = ovr_pulses;
        w0 = words.size();
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            sample = 8'(i);
            valid = 1;
        end
        @(negedge clk);
        valid = 0;
        wait_frames(f + 3, 400);
        chk("ovr_frame0", words[w0], 16'h3000);
        chk("ovr_frame1", words[w0 + 1], 16'h3010);
        chk("ovr_frame2", words[w0 + 2], 16'h3480);
        chk("ovr_pulses", ovr_pulses - o0, 77);
`ifdef OVERRUN_CNT_EN
        chk("ovr_cnt", ovr_cnt, 77);
`endif

        // disable mid-frame with buffer full
        repeat (5) @(negedge clk);
        do_reset();
        enable = 1;
        f = frames;
        o0 = ovr_pulses;
        send(8'h5A, acc);
        send(8'h77, acc);
        wait_bits(5, 100);
        enable = 0;
        #1 chk("dis_ready", ready, 0);
        wait_frames(f + 1, 200);
        chk("dis_word", last_word, 16'h35A0);
        repeat (150) @(negedge clk);
        #1 chk("dis_no_second", frames - f, 1);
        chk("dis_idle", {cs, busy}, 2'b10);
        enable = 1;
        repeat (20) @(negedge clk);
        #1 chk("dis_flushed", {cs, busy}, 2'b10);
        chk("dis_no_overrun", ovr_pulses - o0, 0);

        // async reset mid-frame
        do_reset();
        enable = 1;
        cmd = 4'b0011;
        send(8'hC3, acc);
        wait_bits(8, 100);
        #1 rst_n = 0;
        #1 chk("areset_pins", {cs, sclk, mosi, busy}, 4'b1000);
        #10 rst_n = 1;
        repeat (30) @(negedge clk);
        #1 chk("areset_idle", {cs, busy}, 2'b10);
        f = frames;
        send(8'h0F, acc);
        wait_frames(f + 1, 200);
        chk("areset_new_word", last_word, 16'h30F0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
